// File: rtl/plab5_mcore_mem_addr_arbiter_if.sv
// ---------------------------------------------------------------------------
// plab5_mcore_mem_addr_arbiter_if
//
// One requester-side port of the memory address arbiter: a request channel
// flowing toward the arbiter and a response channel flowing back.
//
// Signals
//   req_control     request message minus its data field
//   req_data        request data
//   req_sec_level   request security level (1 = secure)
//   req_val/rdy     request handshake
//   resp_control    response message minus its data field
//   resp_data       response data
//   resp_sec_level  response security level
//   resp_insecure   response was faked because access was denied
//   resp_val/rdy    response handshake
//
// Modports
//   master  the requester (core / NoC side)
//   slave   the arbiter
// ---------------------------------------------------------------------------
interface plab5_mcore_mem_addr_arbiter_if #(
    parameter int p_req_cnbits  = 45,
    parameter int p_resp_cnbits = 13,
    parameter int p_data_nbits  = 32
);
    logic [p_req_cnbits-1:0]  req_control;
    logic [p_data_nbits-1:0]  req_data;
    logic                     req_sec_level;
    logic                     req_val;
    logic                     req_rdy;

    logic [p_resp_cnbits-1:0] resp_control;
    logic [p_data_nbits-1:0]  resp_data;
    logic                     resp_sec_level;
    logic                     resp_insecure;
    logic                     resp_val;
    logic                     resp_rdy;

    modport master (
        output req_control, req_data, req_sec_level, req_val,
        input  req_rdy,
        input  resp_control, resp_data, resp_sec_level, resp_insecure, resp_val,
        output resp_rdy
    );

    modport slave (
        input  req_control, req_data, req_sec_level, req_val,
        output req_rdy,
        output resp_control, resp_data, resp_sec_level, resp_insecure, resp_val,
        input  resp_rdy
    );
endinterface

// File: rtl/plab5_mcore_mem_addr_arbiter.sv
// ---------------------------------------------------------------------------
// plab5_mcore_mem_addr_arbiter
//
// Shares one memory address-space controller between two requesters. Only
// one transaction is outstanding at a time; requesters are served
// round-robin. Partition-register updates are serialised so the controller
// only ever sees ctrl_par_en while it is idle.
//
// Handshake semantics (every val/rdy pair in this block): a transfer happens
// on the rising clock edge where val and rdy are both 1. A producer that has
// raised val keeps val and its payload stable until that edge. rdy may depend
// combinationally on val; val never depends on rdy.
//
// Ports
//   clk, reset          clock, synchronous active-low reset
//   port0, port1        requester ports (request in, response out)
//   cfg_par_*           partition update request from configuration logic
//   ctrl_req_*          request toward the controller (registered)
//   ctrl_resp_*         response from the controller
//   ctrl_insecure       controller faked the response (access denied)
//   ctrl_par_en/addr    partition register write toward the controller
//   insec_cnt           saturating count of insecure responses delivered
//   dbg_state           current FSM state (0 IDLE, 1 ISSUE, 2 WAIT,
//                       3 CFG, 4 CFG_HOLD)
// ---------------------------------------------------------------------------
module plab5_mcore_mem_addr_arbiter #(
    parameter int  p_opaque_nbits = 8,
    parameter int  p_addr_nbits   = 32,
    parameter int  p_data_nbits   = 32,
    parameter int  p_cnt_nbits    = 8,
    // Mem message layout: type(3) opaque addr len data / type(3) opaque len data
    localparam int c_len_nbits    = $clog2(p_data_nbits / 8),
    localparam int req_cnbits     = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits,
    localparam int resp_cnbits    = 3 + p_opaque_nbits + c_len_nbits
) (
    input  logic                       clk,
    input  logic                       reset,

    plab5_mcore_mem_addr_arbiter_if.slave port0,
    plab5_mcore_mem_addr_arbiter_if.slave port1,

    input  logic                       cfg_par_val,
    input  logic [p_addr_nbits-1:0]    cfg_par_addr,
    input  logic                       cfg_par_sec,
    output logic                       cfg_par_rdy,
    output logic                       cfg_par_err,

    output logic [req_cnbits-1:0]      ctrl_req_control,
    output logic [p_data_nbits-1:0]    ctrl_req_data,
    output logic                       ctrl_req_val,
    input  logic                       ctrl_req_rdy,
    output logic                       ctrl_req_sec_level,

    input  logic [resp_cnbits-1:0]     ctrl_resp_control,
    input  logic [p_data_nbits-1:0]    ctrl_resp_data,
    input  logic                       ctrl_resp_val,
    output logic                       ctrl_resp_rdy,
    input  logic                       ctrl_resp_sec_level,
    input  logic                       ctrl_insecure,

    output logic                       ctrl_par_en,
    output logic [p_addr_nbits-1:0]    ctrl_par_addr,

    output logic [p_cnt_nbits-1:0]     insec_cnt,
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT     = 3'd2,
        S_CFG      = 3'd3,
        S_CFG_HOLD = 3'd4
    } state_t;

    state_t                  state_q;
    logic                    rr_q;       // 0: port0 wins a tie, 1: port1 wins
    logic                    grant_q;    // requester owning the current transaction
    logic [p_cnt_nbits-1:0]  insec_cnt_q;
    logic [req_cnbits-1:0]   req_control_q;
    logic [p_data_nbits-1:0] req_data_q;
    logic                    req_sec_q;
    logic                    req_val_q;
    logic                    par_en_q;
    logic [p_addr_nbits-1:0] par_addr_q;

    // -----------------------------------------------------------------------
    // Combinational handshake decode. Everything is gated with reset so no
    // rdy/val/err escapes while reset is held low.
    // -----------------------------------------------------------------------
    logic idle;
    logic in_wait;
    logic any_req;
    logic pick1;
    logic req_fire;
    logic sel0;
    logic sel1;
    logic resp_done;

    assign idle     = reset && (state_q == S_IDLE);
    assign in_wait  = reset && (state_q == S_WAIT);
    assign any_req  = port0.req_val || port1.req_val;

    // port1 wins if it is the only one asking, or both ask and it is its turn
    assign pick1    = port1.req_val && (!port0.req_val || rr_q);

    // A configuration request (secure or not) blocks request grants that cycle
    assign req_fire = idle && !cfg_par_val && any_req;

    assign port0.req_rdy = req_fire && !pick1;
    assign port1.req_rdy = req_fire &&  pick1;

    assign cfg_par_rdy   = idle && cfg_par_val;
    assign cfg_par_err   = idle && cfg_par_val && !cfg_par_sec;

    // Response path is a straight wire to the granted port during WAIT
    assign sel0 = in_wait && !grant_q;
    assign sel1 = in_wait &&  grant_q;

    assign port0.resp_val       = sel0 && ctrl_resp_val;
    assign port0.resp_control   = sel0 ? ctrl_resp_control : '0;
    assign port0.resp_data      = sel0 ? ctrl_resp_data    : '0;
    assign port0.resp_sec_level = sel0 && ctrl_resp_sec_level;
    assign port0.resp_insecure  = sel0 && ctrl_insecure;

    assign port1.resp_val       = sel1 && ctrl_resp_val;
    assign port1.resp_control   = sel1 ? ctrl_resp_control : '0;
    assign port1.resp_data      = sel1 ? ctrl_resp_data    : '0;
    assign port1.resp_sec_level = sel1 && ctrl_resp_sec_level;
    assign port1.resp_insecure  = sel1 && ctrl_insecure;

    assign ctrl_resp_rdy = (sel0 && port0.resp_rdy) || (sel1 && port1.resp_rdy);
    assign resp_done     = ctrl_resp_val && ctrl_resp_rdy;

    // -----------------------------------------------------------------------
    // FSM with registered controller-side outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rr_q          <= 1'b0;
            grant_q       <= 1'b0;
            insec_cnt_q   <= '0;
            req_control_q <= '0;
            req_data_q    <= '0;
            req_sec_q     <= 1'b0;
            req_val_q     <= 1'b0;
            par_en_q      <= 1'b0;
            par_addr_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_par_val) begin
                        // Rejected updates just pulse cfg_par_err and stay here
                        if (cfg_par_sec) begin
                            par_addr_q <= cfg_par_addr;
                            par_en_q   <= 1'b1;
                            state_q    <= S_CFG;
                        end
                    end else if (any_req) begin
                        grant_q       <= pick1;
                        req_control_q <= pick1 ? port1.req_control   : port0.req_control;
                        req_data_q    <= pick1 ? port1.req_data      : port0.req_data;
                        req_sec_q     <= pick1 ? port1.req_sec_level : port0.req_sec_level;
                        req_val_q     <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (ctrl_req_rdy) begin
                        req_val_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (resp_done) begin
                        rr_q    <= ~grant_q;
                        state_q <= S_IDLE;
                        if (ctrl_insecure && (insec_cnt_q != '1)) begin
                            insec_cnt_q <= insec_cnt_q + 1'b1;
                        end
                    end
                end

                S_CFG: begin
                    par_en_q <= 1'b0;
                    state_q  <= S_CFG_HOLD;
                end

                // Covers the controller's own partition-change cycle
                S_CFG_HOLD: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl_req_control   = req_control_q;
    assign ctrl_req_data      = req_data_q;
    assign ctrl_req_val       = req_val_q;
    assign ctrl_req_sec_level = req_sec_q;
    assign ctrl_par_en        = par_en_q;
    assign ctrl_par_addr      = par_addr_q;
    assign insec_cnt          = insec_cnt_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_plab5_mcore_mem_addr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_plab5_mcore_mem_addr_arbiter
//
// Directed bench for the two-port memory address arbiter. Inputs are driven
// on the falling clock edge and outputs sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_plab5_mcore_mem_addr_arbiter;

  localparam int RQ_W = 45;
  localparam int RS_W = 13;
  localparam int D_W  = 32;
  localparam int A_W  = 32;
  localparam int C_W  = 8;

  localparam logic [31:0] P0_DATA = 32'h0000_00A0;
  localparam logic [31:0] P1_DATA = 32'h0000_00B1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  plab5_mcore_mem_addr_arbiter_if #(.p_req_cnbits(RQ_W), .p_resp_cnbits(RS_W), .p_data_nbits(D_W)) p0_if ();
  plab5_mcore_mem_addr_arbiter_if #(.p_req_cnbits(RQ_W), .p_resp_cnbits(RS_W), .p_data_nbits(D_W)) p1_if ();

  logic            cfg_par_val;
  logic [A_W-1:0]  cfg_par_addr;
  logic            cfg_par_sec;
  logic            cfg_par_rdy;
  logic            cfg_par_err;
  logic [RQ_W-1:0] ctrl_req_control;
  logic [D_W-1:0]  ctrl_req_data;
  logic            ctrl_req_val;
  logic            ctrl_req_rdy;
  logic            ctrl_req_sec_level;
  logic [RS_W-1:0] ctrl_resp_control;
  logic [D_W-1:0]  ctrl_resp_data;
  logic            ctrl_resp_val;
  logic            ctrl_resp_rdy;
  logic            ctrl_resp_sec_level;
  logic            ctrl_insecure;
  logic            ctrl_par_en;
  logic [A_W-1:0]  ctrl_par_addr;
  logic [C_W-1:0]  insec_cnt;
  logic [2:0]      dbg_state;

  plab5_mcore_mem_addr_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .port0               (p0_if),
    .port1               (p1_if),
    .cfg_par_val         (cfg_par_val),
    .cfg_par_addr        (cfg_par_addr),
    .cfg_par_sec         (cfg_par_sec),
    .cfg_par_rdy         (cfg_par_rdy),
    .cfg_par_err         (cfg_par_err),
    .ctrl_req_control    (ctrl_req_control),
    .ctrl_req_data       (ctrl_req_data),
    .ctrl_req_val        (ctrl_req_val),
    .ctrl_req_rdy        (ctrl_req_rdy),
    .ctrl_req_sec_level  (ctrl_req_sec_level),
    .ctrl_resp_control   (ctrl_resp_control),
    .ctrl_resp_data      (ctrl_resp_data),
    .ctrl_resp_val       (ctrl_resp_val),
    .ctrl_resp_rdy       (ctrl_resp_rdy),
    .ctrl_resp_sec_level (ctrl_resp_sec_level),
    .ctrl_insecure       (ctrl_insecure),
    .ctrl_par_en         (ctrl_par_en),
    .ctrl_par_addr       (ctrl_par_addr),
    .insec_cnt           (insec_cnt),
    .dbg_state           (dbg_state)
  );

  int passed = 0;
  int total  = 0;

  function automatic logic [RQ_W-1:0] mk_req(input logic [31:0] addr);
    return {3'd0, 8'h5a, addr, 2'd0};
  endfunction

  // ---------------- driver tasks ----------------
  // Acts as the controller for one transaction: waits (bounded) for the
  // issued request, accepts it, then returns one response with both
  // requester ports ready. Returns at a falling edge with the arbiter idle.
  task automatic run_txn(input logic [31:0] rdata, input logic insec,
                         output logic [31:0] issued, output logic [1:0] resp_seen,
                         output logic ins_seen, output bit ok);
    ok = 1'b0;
    issued = '0;
    resp_seen = 2'b00;
    ins_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (ctrl_req_val) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      issued = ctrl_req_data;
      ctrl_req_rdy = 1'b1;
      @(negedge clk);
      ctrl_req_rdy = 1'b0;
      ctrl_resp_val = 1'b1;
      ctrl_resp_data = rdata;
      ctrl_resp_control = 13'h0a5;
      ctrl_insecure = insec;
      p0_if.resp_rdy = 1'b1;
      p1_if.resp_rdy = 1'b1;
      #1;
      resp_seen = {p1_if.resp_val, p0_if.resp_val};
      ins_seen = p0_if.resp_insecure | p1_if.resp_insecure;
      @(negedge clk);
      ctrl_resp_val = 1'b0;
      ctrl_insecure = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    p0_if.req_val = 1'b0; p0_if.req_control = '0; p0_if.req_data = '0; p0_if.req_sec_level = 1'b0;
    p1_if.req_val = 1'b0; p1_if.req_control = '0; p1_if.req_data = '0; p1_if.req_sec_level = 1'b0;
    p0_if.resp_rdy = 1'b0; p1_if.resp_rdy = 1'b0;
    cfg_par_val = 1'b0; cfg_par_addr = '0; cfg_par_sec = 1'b0;
    ctrl_req_rdy = 1'b0; ctrl_resp_control = '0; ctrl_resp_data = '0;
    ctrl_resp_val = 1'b0; ctrl_resp_sec_level = 1'b0; ctrl_insecure = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    p0_if.req_val = 1'b1;
    cfg_par_val = 1'b1;
    cfg_par_sec = 1'b1;
    #1;
    total++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else passed++;
    total++; if (p0_if.req_rdy !== 1'b0) $display("FAIL reset_req0_rdy: got %b expected 0", p0_if.req_rdy); else passed++;
    total++; if (cfg_par_rdy !== 1'b0) $display("FAIL reset_cfg_rdy: got %b expected 0", cfg_par_rdy); else passed++;
    total++; if (ctrl_req_val !== 1'b0) $display("FAIL reset_ctrl_req_val: got %b expected 0", ctrl_req_val); else passed++;
    total++; if (ctrl_par_en !== 1'b0) $display("FAIL reset_par_en: got %b expected 0", ctrl_par_en); else passed++;
    total++; if (insec_cnt !== 8'd0) $display("FAIL reset_insec_cnt: got %0d expected 0", insec_cnt); else passed++;
    total++; if (ctrl_req_data !== 32'd0) $display("FAIL reset_req_data: got %h expected 0", ctrl_req_data); else passed++;
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    p0_if.req_val = 1'b1;
    p0_if.req_control = mk_req(32'h0000_1000);
    p0_if.req_data = 32'h0;
    p0_if.req_sec_level = 1'b0;
    #1;
    total++; if (p0_if.req_rdy !== 1'b1) $display("FAIL single_req0_rdy: got %b expected 1", p0_if.req_rdy); else passed++;
    total++; if (p1_if.req_rdy !== 1'b0) $display("FAIL single_req1_rdy: got %b expected 0", p1_if.req_rdy); else passed++;
    total++; if (ctrl_req_val !== 1'b0) $display("FAIL single_val_early: got %b expected 0", ctrl_req_val); else passed++;
    @(negedge clk);
    p0_if.req_val = 1'b0;
    #1;
    total++; if (ctrl_req_val !== 1'b1) $display("FAIL single_ctrl_req_val: got %b expected 1", ctrl_req_val); else passed++;
    total++; if (ctrl_req_control !== mk_req(32'h0000_1000)) $display("FAIL single_req_control: got %h expected %h", ctrl_req_control, mk_req(32'h0000_1000)); else passed++;
    total++; if (ctrl_req_sec_level !== 1'b0) $display("FAIL single_req_sec: got %b expected 0", ctrl_req_sec_level); else passed++;
    total++; if (p0_if.req_rdy !== 1'b0) $display("FAIL single_rdy_in_issue: got %b expected 0", p0_if.req_rdy); else passed++;
    ctrl_req_rdy = 1'b1;
    @(negedge clk);
    ctrl_req_rdy = 1'b0;
    ctrl_resp_val = 1'b1;
    ctrl_resp_data = 32'hCAFE_0001;
    ctrl_resp_control = 13'h0aa;
    ctrl_resp_sec_level = 1'b1;
    p0_if.resp_rdy = 1'b1;
    p1_if.resp_rdy = 1'b1;
    #1;
    total++; if (ctrl_req_val !== 1'b0) $display("FAIL single_val_dropped: got %b expected 0", ctrl_req_val); else passed++;
    total++; if (p0_if.resp_val !== 1'b1) $display("FAIL single_resp0_val: got %b expected 1", p0_if.resp_val); else passed++;
    total++; if (p0_if.resp_data !== 32'hCAFE_0001) $display("FAIL single_resp0_data: got %h expected cafe0001", p0_if.resp_data); else passed++;
    total++; if (p0_if.resp_control !== 13'h0aa) $display("FAIL single_resp0_control: got %h expected 0aa", p0_if.resp_control); else passed++;
    total++; if (p0_if.resp_sec_level !== 1'b1) $display("FAIL single_resp0_sec: got %b expected 1", p0_if.resp_sec_level); else passed++;
    total++; if (p1_if.resp_val !== 1'b0) $display("FAIL single_resp1_val: got %b expected 0", p1_if.resp_val); else passed++;
    total++; if (ctrl_resp_rdy !== 1'b1) $display("FAIL single_ctrl_resp_rdy: got %b expected 1", ctrl_resp_rdy); else passed++;
    @(negedge clk);
    ctrl_resp_val = 1'b0;
    ctrl_resp_sec_level = 1'b0;
    #1;
    total++; if (dbg_state !== 3'd0) $display("FAIL single_back_idle: got %0d expected 0", dbg_state); else passed++;
    total++; if (insec_cnt !== 8'd0) $display("FAIL single_insec_cnt: got %0d expected 0", insec_cnt); else passed++;
  endtask

  task automatic test_round_robin();
    logic [31:0] issued;
    logic [1:0]  seen;
    logic        ins;
    bit          ok;
    logic [31:0] exp_data;
    logic [1:0]  exp_seen;
    @(negedge clk);
    reset = 1'b0;
    p0_if.req_val = 1'b1; p0_if.req_data = P0_DATA; p0_if.req_control = mk_req(32'h100);
    p1_if.req_val = 1'b1; p1_if.req_data = P1_DATA; p1_if.req_control = mk_req(32'h200);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_txn(32'h0000_1100 + k, 1'b0, issued, seen, ins, ok);
      exp_data = (k % 2 == 0) ? P0_DATA : P1_DATA;
      exp_seen = (k % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (!ok) $display("FAIL rr_issue_timeout: txn %0d got no ctrl_req_val expected one", k); else passed++;
      total++; if (issued !== exp_data) $display("FAIL rr_grant: txn %0d got %h expected %h", k, issued, exp_data); else passed++;
      total++; if (seen !== exp_seen) $display("FAIL rr_resp_route: txn %0d got %b expected %b", k, seen, exp_seen); else passed++;
    end
    p0_if.req_val = 1'b0;
    p1_if.req_val = 1'b0;
  endtask

  task automatic test_cfg_priority();
    logic [31:0] issued;
    logic [1:0]  seen;
    logic        ins;
    bit          ok;
    @(negedge clk);
    p1_if.req_val = 1'b1;
    p1_if.req_data = P1_DATA;
    cfg_par_val = 1'b1;
    cfg_par_addr = 32'h0000_8000;
    cfg_par_sec = 1'b1;
    #1;
    total++; if (cfg_par_rdy !== 1'b1) $display("FAIL cfg_rdy: got %b expected 1", cfg_par_rdy); else passed++;
    total++; if (cfg_par_err !== 1'b0) $display("FAIL cfg_err_secure: got %b expected 0", cfg_par_err); else passed++;
    total++; if (p1_if.req_rdy !== 1'b0) $display("FAIL cfg_blocks_req1: got %b expected 0", p1_if.req_rdy); else passed++;
    @(negedge clk);
    cfg_par_val = 1'b0;
    #1;
    total++; if (ctrl_par_en !== 1'b1) $display("FAIL cfg_par_en_on: got %b expected 1", ctrl_par_en); else passed++;
    total++; if (ctrl_par_addr !== 32'h0000_8000) $display("FAIL cfg_par_addr: got %h expected 00008000", ctrl_par_addr); else passed++;
    total++; if (ctrl_req_val !== 1'b0) $display("FAIL cfg_no_req_val: got %b expected 0", ctrl_req_val); else passed++;
    total++; if (p1_if.req_rdy !== 1'b0) $display("FAIL cfg_req1_wait1: got %b expected 0", p1_if.req_rdy); else passed++;
    @(negedge clk);
    #1;
    total++; if (ctrl_par_en !== 1'b0) $display("FAIL cfg_par_en_off: got %b expected 0", ctrl_par_en); else passed++;
    total++; if (p1_if.req_rdy !== 1'b0) $display("FAIL cfg_req1_wait2: got %b expected 0", p1_if.req_rdy); else passed++;
    @(negedge clk);
    #1;
    total++; if (p1_if.req_rdy !== 1'b1) $display("FAIL cfg_req1_grant_at_3: got %b expected 1", p1_if.req_rdy); else passed++;
    total++; if (ctrl_par_en !== 1'b0) $display("FAIL cfg_par_en_once: got %b expected 0", ctrl_par_en); else passed++;
    run_txn(32'h0000_2222, 1'b0, issued, seen, ins, ok);
    p1_if.req_val = 1'b0;
    total++; if (!ok) $display("FAIL cfg_issue_timeout: got no ctrl_req_val expected one"); else passed++;
    total++; if (issued !== P1_DATA) $display("FAIL cfg_then_req1: got %h expected %h", issued, P1_DATA); else passed++;
    total++; if (seen !== 2'b10) $display("FAIL cfg_resp_route: got %b expected 10", seen); else passed++;
    total++; if (ctrl_par_addr !== 32'h0000_8000) $display("FAIL cfg_addr_hold: got %h expected 00008000", ctrl_par_addr); else passed++;
  endtask

  task automatic test_cfg_insecure();
    @(negedge clk);
    cfg_par_val = 1'b1;
    cfg_par_addr = 32'h0000_4000;
    cfg_par_sec = 1'b0;
    p0_if.req_val = 1'b1;
    p0_if.req_data = P0_DATA;
    #1;
    total++; if (cfg_par_err !== 1'b1) $display("FAIL cfgbad_err_pulse: got %b expected 1", cfg_par_err); else passed++;
    total++; if (cfg_par_rdy !== 1'b1) $display("FAIL cfgbad_rdy: got %b expected 1", cfg_par_rdy); else passed++;
    total++; if (p0_if.req_rdy !== 1'b0) $display("FAIL cfgbad_no_grant: got %b expected 0", p0_if.req_rdy); else passed++;
    @(negedge clk);
    cfg_par_val = 1'b0;
    p0_if.req_val = 1'b0;
    #1;
    total++; if (cfg_par_err !== 1'b0) $display("FAIL cfgbad_err_one_cycle: got %b expected 0", cfg_par_err); else passed++;
    total++; if (ctrl_par_en !== 1'b0) $display("FAIL cfgbad_par_en: got %b expected 0", ctrl_par_en); else passed++;
    total++; if (dbg_state !== 3'd0) $display("FAIL cfgbad_stay_idle: got %0d expected 0", dbg_state); else passed++;
    total++; if (ctrl_par_addr !== 32'h0000_8000) $display("FAIL cfgbad_addr_kept: got %h expected 00008000", ctrl_par_addr); else passed++;
    @(negedge clk);
    #1;
    total++; if (ctrl_par_en !== 1'b0) $display("FAIL cfgbad_par_en_later: got %b expected 0", ctrl_par_en); else passed++;
    total++; if (ctrl_req_val !== 1'b0) $display("FAIL cfgbad_no_req: got %b expected 0", ctrl_req_val); else passed++;
  endtask

  task automatic test_insecure_saturation();
    logic [31:0] issued;
    logic [1:0]  seen;
    logic        ins;
    bit          ok;
    logic [1:0]  exp_seen;
    logic [7:0]  exp_cnt;
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        p0_if.req_val = 1'b1; p0_if.req_data = P0_DATA;
        exp_seen = 2'b01;
      end else begin
        p1_if.req_val = 1'b1; p1_if.req_data = P1_DATA;
        exp_seen = 2'b10;
      end
      run_txn(32'h3000_0000 + i, 1'b1, issued, seen, ins, ok);
      p0_if.req_val = 1'b0;
      p1_if.req_val = 1'b0;
      exp_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      total++; if (!ok || seen !== exp_seen) $display("FAIL sat_route: txn %0d got %b expected %b", i, seen, exp_seen); else passed++;
      total++; if (ins !== 1'b1) $display("FAIL sat_insecure_flag: txn %0d got %b expected 1", i, ins); else passed++;
      total++; if (insec_cnt !== exp_cnt) $display("FAIL sat_insec_cnt: txn %0d got %0d expected %0d", i, insec_cnt, exp_cnt); else passed++;
    end
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] issued;
    logic [1:0]  seen;
    logic        ins;
    bit          ok;
    // Complete one port0 transaction so port1 holds round-robin priority
    p0_if.req_val = 1'b1; p0_if.req_data = P0_DATA;
    run_txn(32'h0000_4444, 1'b0, issued, seen, ins, ok);
    p0_if.req_val = 1'b0;
    total++; if (!ok || issued !== P0_DATA) $display("FAIL bp_setup: got %h expected %h", issued, P0_DATA); else passed++;
    p1_if.req_val = 1'b1; p1_if.req_data = P1_DATA;
    @(negedge clk);
    p1_if.req_val = 1'b0;
    #1;
    total++; if (ctrl_req_val !== 1'b1 || ctrl_req_data !== P1_DATA) $display("FAIL bp_issue: got val %b data %h expected val 1 data %h", ctrl_req_val, ctrl_req_data, P1_DATA); else passed++;
    ctrl_req_rdy = 1'b1;
    @(negedge clk);
    ctrl_req_rdy = 1'b0;
    ctrl_resp_val = 1'b1;
    ctrl_resp_data = 32'h5555_AAAA;
    p1_if.resp_rdy = 1'b0;
    p0_if.resp_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (ctrl_resp_rdy !== 1'b0) $display("FAIL bp_resp_rdy: cycle %0d got %b expected 0", k, ctrl_resp_rdy); else passed++;
      total++; if (p1_if.resp_val !== 1'b1 || p1_if.resp_data !== 32'h5555_AAAA) $display("FAIL bp_resp_stable: cycle %0d got val %b data %h expected val 1 data 5555aaaa", k, p1_if.resp_val, p1_if.resp_data); else passed++;
      total++; if (p0_if.resp_val !== 1'b0) $display("FAIL bp_other_port: cycle %0d got %b expected 0", k, p0_if.resp_val); else passed++;
      total++; if (dbg_state !== 3'd2) $display("FAIL bp_state_wait: cycle %0d got %0d expected 2", k, dbg_state); else passed++;
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    total++; if (p1_if.resp_val !== 1'b0) $display("FAIL bp_reset_gates_resp: got %b expected 0", p1_if.resp_val); else passed++;
    @(negedge clk);
    reset = 1'b1;
    ctrl_resp_val = 1'b0;
    #1;
    total++; if (dbg_state !== 3'd0) $display("FAIL bp_reset_idle: got %0d expected 0", dbg_state); else passed++;
    total++; if (ctrl_req_val !== 1'b0) $display("FAIL bp_reset_req_val: got %b expected 0", ctrl_req_val); else passed++;
    total++; if (insec_cnt !== 8'd0) $display("FAIL bp_reset_insec_cnt: got %0d expected 0", insec_cnt); else passed++;
    total++; if (ctrl_par_addr !== 32'd0) $display("FAIL bp_reset_par_addr: got %h expected 0", ctrl_par_addr); else passed++;
    p0_if.req_val = 1'b1;
    p1_if.req_val = 1'b1;
    #1;
    total++; if (p0_if.req_rdy !== 1'b1) $display("FAIL bp_post_reset_req0: got %b expected 1", p0_if.req_rdy); else passed++;
    total++; if (p1_if.req_rdy !== 1'b0) $display("FAIL bp_post_reset_req1: got %b expected 0", p1_if.req_rdy); else passed++;
    p0_if.req_val = 1'b0;
    p1_if.req_val = 1'b0;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_cfg_priority();
    test_cfg_insecure();
    test_insecure_saturation();
    test_backpressure_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
